info_port_decoder: RTL and testbench

Receive side of the info-record interface: accepts packed info records (4-bit `port_num`) over a valid/ready stream, buffers them in a small FIFO, and presents each one as a one-hot per-port request to the addressed consumer. Sits between the record producer and the per-port consumers. Records addressing ports at or above `NPORTS` are dropped and counted.

---
 rtl/info_port_decoder_if.sv | 28 ++
 rtl/info_port_decoder.sv | 92 +++++++++
 tb/tb_info_port_decoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/info_port_decoder_if.sv
// Info-record stream interface: producer-side record handshake, per-port dispatch and status.
interface info_port_decoder_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NPORTS = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [3:0]        in_info;
    logic              in_ready;
    logic [NPORTS-1:0] port_valid;
    logic [NPORTS-1:0] port_ready;
    logic [LW-1:0]     level;
    logic [7:0]        err_count;
    logic              err_pulse;

    // Environment side: offers records and accepts per-port requests
    modport master (
        output in_valid, in_info, port_ready,
        input  in_ready, port_valid, level, err_count, err_pulse
    );

    // Decoder side
    modport slave (
        input  in_valid, in_info, port_ready,
        output in_ready, port_valid, level, err_count, err_pulse
    );
endinterface

// File: rtl/info_port_decoder.sv
// Buffers info records in a small FIFO and dispatches the head record as a one-hot
// request to the addressed port. Records naming a port >= NPORTS are dropped and counted.
module info_port_decoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NPORTS = 16
) (
    input logic               clk,
    input logic               res,
    info_port_decoder_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [4:0]  NPORTS_W = 5'(NPORTS);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [3:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [7:0]        err_count_q;
    logic              err_pulse_q;

    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic              not_empty;
    logic [3:0]        head;
    logic [NPORTS-1:0] port_sel;

    // Handshake, legality and dispatch decode from registered state
    always_comb begin
        not_empty = (level_q != '0);
        accept    = bus.in_valid && (level_q != FULL_LEVEL);
        legal     = ({1'b0, bus.in_info} < NPORTS_W);
        push      = accept && legal;
        head      = mem[rd_ptr_q];
        port_sel  = NPORTS'(1) << head;
        // Only the ready bit of the addressed port can pop the head
        pop       = not_empty && (|(bus.port_ready & port_sel));
    end

    // Output drive
    always_comb begin
        bus.in_ready   = (level_q != FULL_LEVEL);
        bus.port_valid = not_empty ? port_sel : '0;
        bus.level      = level_q;
        bus.err_count  = err_count_q;
        bus.err_pulse  = err_pulse_q;
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_info;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Illegal-record drop pulse and saturating drop counter
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= accept && !legal;
            if (accept && !legal && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_info_port_decoder.sv
// Directed bench: dut_a (DEPTH 4, NPORTS 16) for dispatch/FIFO, dut_b (NPORTS 8) for drops.
module tb_info_port_decoder;
    logic clk;
    logic res;
    int   n_checks;
    int   n_errors;

    info_port_decoder_if #(.DEPTH(4), .NPORTS(16)) bus_a ();
    info_port_decoder_if #(.DEPTH(4), .NPORTS(8))  bus_b ();

    info_port_decoder #(.DEPTH(4), .NPORTS(16)) dut_a (
        .clk (clk),
        .res (res),
        .bus (bus_a)
    );

    info_port_decoder #(.DEPTH(4), .NPORTS(8)) dut_b (
        .clk (clk),
        .res (res),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        res = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_info = 4'd0;
        bus_a.port_ready = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_info = 4'd0;
        bus_b.port_ready = '0;

        // Reset state while res is high
        #3;
        check_eq("rst_pv", 32'(bus_a.port_valid), 32'h0);
        check_eq("rst_level", 32'(bus_a.level), 32'd0);
        check_eq("rst_errcnt", 32'(bus_a.err_count), 32'd0);
        check_eq("rst_ready", 32'(bus_a.in_ready), 32'd1);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_level", 32'(bus_a.level), 32'd0);
        check_eq("idle_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("idle_pv", 32'(bus_a.port_valid), 32'h0);

        // Single record to port 5
        bus_a.in_valid = 1'b1;
        bus_a.in_info = 4'd5;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        check_eq("single_pv", 32'(bus_a.port_valid), 32'h0020);
        check_eq("single_level", 32'(bus_a.level), 32'd1);
        bus_a.port_ready = 16'h0020;
        @(negedge clk);
        check_eq("single_pop_pv", 32'(bus_a.port_valid), 32'h0);
        check_eq("single_pop_level", 32'(bus_a.level), 32'd0);
        bus_a.port_ready = '0;

        // Fill with ports 1..4, then a 5th offer while full
        for (int i = 1; i <= 4; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_info = 4'(i);
            @(negedge clk);
        end
        bus_a.in_info = 4'd6;
        check_eq("full_ready", 32'(bus_a.in_ready), 32'd0);
        check_eq("full_level", 32'(bus_a.level), 32'd4);
        @(negedge clk);
        check_eq("full_nopush_level", 32'(bus_a.level), 32'd4);
        bus_a.in_valid = 1'b0;
        bus_a.port_ready = 16'hFFFF;
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("drain_pv%0d", k), 32'(bus_a.port_valid), 32'h1 << k);
            if (k == 2) check_eq("drain_ready_back", 32'(bus_a.in_ready), 32'd1);
            @(negedge clk);
        end
        check_eq("drain_level", 32'(bus_a.level), 32'd0);
        check_eq("drain_pv_empty", 32'(bus_a.port_valid), 32'h0);
        bus_a.port_ready = '0;

        // Wrong-port ready does not pop port 7
        bus_a.in_valid = 1'b1;
        bus_a.in_info = 4'd7;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_a.port_ready = 16'h0001;
        @(negedge clk);
        @(negedge clk);
        check_eq("wrong_ready_pv", 32'(bus_a.port_valid), 32'h0080);
        check_eq("wrong_ready_level", 32'(bus_a.level), 32'd1);
        bus_a.port_ready = 16'h0080;
        @(negedge clk);
        check_eq("right_ready_level", 32'(bus_a.level), 32'd0);
        bus_a.port_ready = '0;

        // Preload 10, 11 (write pointer wraps from 3 to 0), then push/pop together
        for (int i = 10; i <= 11; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_info = 4'(i);
            @(negedge clk);
        end
        bus_a.port_ready = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            bus_a.in_valid = (k < 3);
            bus_a.in_info = 4'(12 + k);
            check_eq($sformatf("stream_pv%0d", k), 32'(bus_a.port_valid), 32'h1 << (10 + k));
            check_eq($sformatf("stream_level%0d", k), 32'(bus_a.level), 32'd2);
            @(negedge clk);
        end
        bus_a.port_ready = '0;
        check_eq("stream_pv_end", 32'(bus_a.port_valid), 32'h1 << 14);

        // Asynchronous reset mid-stream
        #1 res = 1'b1;
        #1;
        check_eq("midrst_pv", 32'(bus_a.port_valid), 32'h0);
        check_eq("midrst_level", 32'(bus_a.level), 32'd0);
        check_eq("midrst_ready", 32'(bus_a.in_ready), 32'd1);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check_eq("postrst_level", 32'(bus_a.level), 32'd0);

        // Illegal port 9 on the 8-port decoder
        check_eq("b_ready", 32'(bus_b.in_ready), 32'd1);
        bus_b.in_valid = 1'b1;
        bus_b.in_info = 4'd9;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        check_eq("ill_pulse", 32'(bus_b.err_pulse), 32'd1);
        check_eq("ill_count", 32'(bus_b.err_count), 32'd1);
        check_eq("ill_level", 32'(bus_b.level), 32'd0);
        check_eq("ill_pv", 32'(bus_b.port_valid), 32'h0);
        @(negedge clk);
        check_eq("ill_pulse_end", 32'(bus_b.err_pulse), 32'd0);

        // 300 more drops saturate the counter
        bus_b.in_valid = 1'b1;
        bus_b.in_info = 4'd15;
        for (int i = 0; i < 300; i++) @(negedge clk);
        bus_b.in_valid = 1'b0;
        check_eq("sat_count", 32'(bus_b.err_count), 32'd255);
        check_eq("sat_level", 32'(bus_b.level), 32'd0);

        // Legal record on the 8-port decoder still dispatches
        bus_b.in_valid = 1'b1;
        bus_b.in_info = 4'd7;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        check_eq("b_legal_pv", 32'(bus_b.port_valid), 32'h80);
        check_eq("b_legal_nopulse", 32'(bus_b.err_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
